// File: rtl/m_uart_rx_wb_if.sv
// m_uart_rx_wb_if: Wishbone classic signal bundle between the midgetv IO bus
// (master side) and the UART receiver responder (slave side).
interface m_uart_rx_wb_if;
   logic        STB_I;
   logic        WE_I;
   logic        ADR_I;
   logic [11:0] DAT_I;
   logic [31:0] DAT_O;
   logic        ACK_O;

   modport master (
      output STB_I, WE_I, ADR_I, DAT_I,
      input  DAT_O, ACK_O
   );

   modport slave (
      input  STB_I, WE_I, ADR_I, DAT_I,
      output DAT_O, ACK_O
   );
endinterface

// File: rtl/m_uart_rx_wb.sv
// m_uart_rx_wb: 8N1 UART receiver feeding a small byte FIFO, read by the CPU
// through a Wishbone classic responder (DATA at ADR_I=0, STATUS at ADR_I=1).
// Optional feature macro: UART_RX_IRQ_EN adds the irq output and an irqen
// register (written from DAT_I[0], read back at DAT_O[13]).
module m_uart_rx_wb #(
   parameter int DIVISOR  = 104,
   parameter int FIFOLOG2 = 2
) (
   input  logic          CLK_I,
   input  logic          RST_In,
   m_uart_rx_wb_if.slave wb,
   input  logic          usartRX
`ifdef UART_RX_IRQ_EN
   ,
   output logic          irq
`endif
);
   localparam int DEPTH = 1 << FIFOLOG2;
   localparam logic [15:0] HALF_LOAD = 16'(DIVISOR / 2 - 1);
   localparam logic [15:0] BIT_LOAD  = 16'(DIVISOR - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   logic                rx_meta;
   logic                rxs;
   state_t              state;
   logic [15:0]         timer;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;
   logic [7:0]          mem [DEPTH];
   logic [FIFOLOG2-1:0] wptr;
   logic [FIFOLOG2-1:0] rptr;
   logic [FIFOLOG2:0]   count;
   logic                ovr;
   logic                ferr;
   logic                irqen_bit;
   logic                unused_bits;

   // Receiver events are decoded from the FSM registers so a push lands in
   // the very cycle the stop bit is sampled.
   logic timer_zero, rx_done, rx_frame_err;
   assign timer_zero   = (timer == 16'd0);
   assign rx_done      = (state == STOP) && timer_zero && rxs;
   assign rx_frame_err = (state == STOP) && timer_zero && !rxs;

   // Bus decode: side effects only in the strobe cycle that is not yet acked.
   logic access, rd, wr, nonempty, full, pop, flush, push_ok, drop;
   logic [7:0] head;
   assign access   = wb.STB_I & ~wb.ACK_O;
   assign rd       = access & ~wb.WE_I;
   assign wr       = access & wb.WE_I;
   assign nonempty = (count != '0);
   assign full     = count[FIFOLOG2];
   assign pop      = rd & ~wb.ADR_I & nonempty;
   assign flush    = wr & wb.DAT_I[11];
   assign push_ok  = rx_done & ~flush & (~full | pop);
   assign drop     = rx_done & ~flush & full & ~pop;
   assign head     = nonempty ? mem[rptr] : 8'h00;

   // Two-flop synchroniser for the asynchronous serial line, idling high.
   always_ff @(posedge CLK_I or negedge RST_In) begin
      if (!RST_In) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= usartRX;
         rxs     <= rx_meta;
      end
   end

   // Receiver FSM: half-bit wait to the start centre, then one sample per bit time.
   always_ff @(posedge CLK_I or negedge RST_In) begin
      if (!RST_In) begin
         state   <= IDLE;
         timer   <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  timer <= HALF_LOAD;
                  state <= START;
               end
            end
            START: begin
               if (!timer_zero) begin
                  timer <= timer - 16'd1;
               end else if (rxs) begin
                  state <= IDLE;
               end else begin
                  timer   <= BIT_LOAD;
                  bit_idx <= 3'd0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (!timer_zero) begin
                  timer <= timer - 16'd1;
               end else begin
                  shreg   <= {rxs, shreg[7:1]};
                  timer   <= BIT_LOAD;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= STOP;
               end
            end
            STOP: begin
               if (!timer_zero) timer <= timer - 16'd1;
               else             state <= rxs ? IDLE : BRK;
            end
            BRK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage holds data only, so it carries no reset.
   always_ff @(posedge CLK_I) begin
      if (push_ok) mem[wptr] <= shreg;
   end

   // FIFO pointers/count, sticky flags, and the Wishbone ACK/DAT_O registers.
   always_ff @(posedge CLK_I or negedge RST_In) begin
      if (!RST_In) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         ovr      <= 1'b0;
         ferr     <= 1'b0;
         wb.ACK_O <= 1'b0;
         wb.DAT_O <= 32'd0;
      end else begin
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            count <= count + {{FIFOLOG2{1'b0}}, push_ok} - {{FIFOLOG2{1'b0}}, pop};
         end
         // A set in the same cycle as a clear wins.
         if (drop)                      ovr <= 1'b1;
         else if (wr && wb.DAT_I[9])    ovr <= 1'b0;
         if (rx_frame_err)              ferr <= 1'b1;
         else if (wr && wb.DAT_I[10])   ferr <= 1'b0;
         wb.ACK_O <= access;
         // DAT_O is zero outside a read so it can be ORed onto a shared bus.
         if (rd) wb.DAT_O <= {18'd0, irqen_bit, rxs, full, ferr, ovr, nonempty, head};
         else    wb.DAT_O <= 32'd0;
      end
   end

`ifdef UART_RX_IRQ_EN
   logic irqen;
   assign irqen_bit   = irqen;
   assign unused_bits = ^wb.DAT_I[8:1];

   // Interrupt enable register and registered level interrupt.
   always_ff @(posedge CLK_I or negedge RST_In) begin
      if (!RST_In) begin
         irqen <= 1'b0;
         irq   <= 1'b0;
      end else begin
         if (wr) irqen <= wb.DAT_I[0];
         irq <= irqen & (nonempty | ovr | ferr);
      end
   end
`else
   assign irqen_bit   = 1'b0;
   assign unused_bits = ^wb.DAT_I[8:0];
`endif

endmodule

// File: tb/tb_m_uart_rx_wb.sv
// tb_m_uart_rx_wb: self-checking bench for m_uart_rx_wb with DIVISOR=16 and a
// depth-4 FIFO. Expected words come from a queue-based model of the register map.
module tb_m_uart_rx_wb;
   localparam int DIV   = 16;
   localparam int DEPTH = 4;

   logic CLK_I   = 1'b0;
   logic RST_In  = 1'b0;
   logic usartRX = 1'b1;
`ifdef UART_RX_IRQ_EN
   logic irq;
`endif

   m_uart_rx_wb_if bus();

   m_uart_rx_wb #(.DIVISOR(DIV), .FIFOLOG2(2)) dut (
      .CLK_I   (CLK_I),
      .RST_In  (RST_In),
      .wb      (bus),
      .usartRX (usartRX)
`ifdef UART_RX_IRQ_EN
      ,
      .irq     (irq)
`endif
   );

   always #5 CLK_I = ~CLK_I;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: bytes held in the FIFO and the sticky flags.
   logic [7:0] mq [$];
   logic       movr  = 1'b0;
   logic       mferr = 1'b0;

   typedef struct {
      logic        we;
      logic        adr;
      logic [11:0] din;
      logic [31:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Register word for a read with the line idle high.
   function automatic logic [31:0] exp_word();
      logic [31:0] w;
      w = 32'h1000;
      if (mq.size() != 0) w = w | 32'h100 | {24'd0, mq[0]};
      if (movr)  w = w | 32'h200;
      if (mferr) w = w | 32'h400;
      if (mq.size() == DEPTH) w = w | 32'h800;
      return w;
   endfunction

   // One Wishbone transfer; called at posedge+1, returns at posedge+1.
   task automatic wb_xfer(input logic we, input logic adr, input logic [11:0] d, output logic [31:0] q);
      bus.STB_I = 1'b1;
      bus.WE_I  = we;
      bus.ADR_I = adr;
      bus.DAT_I = d;
      @(posedge CLK_I); #1;
      check("ack", {31'd0, bus.ACK_O}, 32'd1);
      q = bus.DAT_O;
      bus.STB_I = 1'b0;
      bus.WE_I  = 1'b0;
      bus.DAT_I = 12'd0;
      @(posedge CLK_I); #1;
   endtask

   // One 8N1 frame at DIV clocks per bit; called at posedge+1.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         usartRX = bits[i];
         repeat (DIV) @(posedge CLK_I);
         #1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q;
      vec_t vecs [8];
      bus.STB_I = 1'b0;
      bus.WE_I  = 1'b0;
      bus.ADR_I = 1'b0;
      bus.DAT_I = 12'd0;

      // Reset state
      #1;
      check("reset_ack", {31'd0, bus.ACK_O}, 32'd0);
      check("reset_dat", bus.DAT_O, 32'd0);
      repeat (3) @(posedge CLK_I);
      #1 RST_In = 1'b1;
      @(posedge CLK_I); #1;
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("status_after_reset", q, 32'h1000);

      // Single byte 0xA5
      send_frame(8'hA5, 1'b1);
      wb_xfer(1'b0, 1'b0, 12'd0, q);
      check("a5_data", q, 32'h1000 | 32'h100 | 32'hA5);
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("a5_status_empty", q, 32'h1000);

      // Overflow: five bytes into a depth-4 FIFO, then table-driven reads
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
      vecs[0] = '{1'b0, 1'b1, 12'h000, 32'h1B01};
      vecs[1] = '{1'b0, 1'b0, 12'h000, 32'h1B01};
      vecs[2] = '{1'b0, 1'b0, 12'h000, 32'h1302};
      vecs[3] = '{1'b0, 1'b0, 12'h000, 32'h1303};
      vecs[4] = '{1'b0, 1'b0, 12'h000, 32'h1304};
      vecs[5] = '{1'b0, 1'b0, 12'h000, 32'h1200};
      vecs[6] = '{1'b1, 1'b1, 12'h200, 32'h0000};
      vecs[7] = '{1'b0, 1'b1, 12'h000, 32'h1000};
      for (int i = 0; i < 8; i++) begin
         wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].din, q);
         check($sformatf("ovr_vec%0d", i), q, vecs[i].exp);
      end

      // Framing error: stop bit low, line held low, then released
      send_frame(8'h55, 1'b0);
      repeat (40) @(posedge CLK_I);
      #1 usartRX = 1'b1;
      repeat (10) @(posedge CLK_I);
      #1;
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("ferr_status", q, 32'h1400);
      wb_xfer(1'b1, 1'b0, 12'h400, q);
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("ferr_cleared", q, 32'h1000);

      // Short low glitch is rejected at the start-centre check
      usartRX = 1'b0;
      repeat (3) @(posedge CLK_I);
      #1 usartRX = 1'b1;
      repeat (40) @(posedge CLK_I);
      #1;
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("glitch_status", q, 32'h1000);

      // Full FIFO with a DATA pop landing in the stop-sample push cycle
      for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("full_status", q, 32'h1911);
      fork
         send_frame(8'h15, 1'b1);
         begin
            repeat (154) @(posedge CLK_I);
            #1;
            bus.STB_I = 1'b1;
            bus.WE_I  = 1'b0;
            bus.ADR_I = 1'b0;
            @(posedge CLK_I); #1;
            check("sim_ack", {31'd0, bus.ACK_O}, 32'd1);
            check("sim_pop_data", bus.DAT_O, 32'h1911);
            bus.STB_I = 1'b0;
         end
      join
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("sim_status_no_ovr", q, 32'h1912);
      for (int i = 0; i < 4; i++) begin
         wb_xfer(1'b0, 1'b0, 12'd0, q);
         check($sformatf("sim_drain%0d", i), q,
               ((i == 0) ? 32'h1900 : 32'h1100) | 32'(8'h12 + 8'(i)));
      end

      // Back-to-back strobe: ACK on alternate cycles
      bus.STB_I = 1'b1;
      bus.ADR_I = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK_I); #1;
         check($sformatf("b2b_ack%0d", i), {31'd0, bus.ACK_O}, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      bus.STB_I = 1'b0;
      @(posedge CLK_I); #1;

      // Reset asserted in the middle of data bit 4
      send_frame(8'h77, 1'b1);
      usartRX = 1'b0;
      repeat (DIV * 5 + DIV / 2) @(posedge CLK_I);
      #1;
      bus.STB_I = 1'b1;
      bus.ADR_I = 1'b1;
      @(posedge CLK_I); #1;
      check("midframe_status", bus.DAT_O, 32'h0177);
      RST_In = 1'b0;
      #1;
      check("async_rst_ack", {31'd0, bus.ACK_O}, 32'd0);
      check("async_rst_dat", bus.DAT_O, 32'd0);
      bus.STB_I = 1'b0;
      usartRX   = 1'b1;
      repeat (3) @(posedge CLK_I);
      #1 RST_In = 1'b1;
      repeat (5) @(posedge CLK_I);
      #1;
      wb_xfer(1'b0, 1'b1, 12'd0, q);
      check("post_rst_status", q, 32'h1000);
      send_frame(8'h3C, 1'b1);
      wb_xfer(1'b0, 1'b0, 12'd0, q);
      check("post_rst_3c", q, 32'h113C);

      // Randomized frames and reads against the queue model
      for (int r = 0; r < 4; r++) begin
         int n;
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            send_frame(b, 1'b1);
            if (mq.size() < DEPTH) mq.push_back(b);
            else movr = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
               logic [31:0] e;
               e = exp_word();
               wb_xfer(1'b0, 1'b0, 12'd0, q);
               check("rand_read", q, e);
               if (mq.size() != 0) void'(mq.pop_front());
            end
         end
         wb_xfer(1'b0, 1'b1, 12'd0, q);
         check("rand_status", q, exp_word());
         while (mq.size() != 0) begin
            logic [31:0] e;
            e = exp_word();
            wb_xfer(1'b0, 1'b0, 12'd0, q);
            check("rand_drain", q, e);
            void'(mq.pop_front());
         end
         wb_xfer(1'b0, 1'b0, 12'd0, q);
         check("rand_empty_read", q, exp_word());
         wb_xfer(1'b1, 1'b1, 12'h200, q);
         movr = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
